// File: rtl/manchester_pkg.sv
// manchester_pkg: shared state encoding and timing-window helpers for the Manchester receiver
package manchester_pkg;
  typedef enum logic {IDLE, LOCKED} state_e;
  function automatic int osr(input int osc_fre, input int data_rate);
    return osc_fre / data_rate;
  endfunction
  function automatic int win_lo(input int o);
    return 3 * o / 4;
  endfunction
  function automatic int win_hi(input int o);
    return 5 * o / 4;
  endfunction
  function automatic int cnt_w(input int o);
    return $clog2(5 * o / 4 + 2);
  endfunction
endpackage

// File: rtl/manchester_edge_sync.sv
// manchester_edge_sync: two-flop synchroniser with registered rise/fall strobes and synced level
module manchester_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o,
  output logic level_o
);
  logic [2:0] sync_q;
  logic rise_q, fall_q, level_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], din_i};
      rise_q  <= sync_q[1] & ~sync_q[2];
      fall_q  <= ~sync_q[1] & sync_q[2];
      level_q <= sync_q[1];
    end
  end
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign level_o = level_q;
endmodule

// File: rtl/manchester_rx_deser.sv
// manchester_rx_deser: locks on a Manchester start bit, recovers the bit clock and deserialises words
module manchester_rx_deser
  import manchester_pkg::*;
#(
  parameter int OSC_FRE   = 32,
  parameter int DATA_RATE = 2,
  parameter int DATA_W    = 8,
  parameter int POLARITY  = 0,
  parameter int LSB_FIRST = 1
) (
  input  logic              osc,
  input  logic              rst,
  input  logic              manchester_data,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              balanced_clk,
  output logic              frame_active,
  output logic              bit_err,
  output logic              overrun
);
  localparam int OSR = osr(OSC_FRE, DATA_RATE);
  localparam int CW  = cnt_w(OSR);
  localparam int BW  = $clog2(DATA_W + 1);
  localparam int HW  = $clog2(OSR / 2);
  localparam logic [CW-1:0] LO  = CW'(win_lo(OSR));
  localparam logic [CW-1:0] HI  = CW'(win_hi(OSR));
  localparam logic [CW-1:0] END = CW'(win_hi(OSR) + 1);
  state_e state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_cnt_q;
  logic [HW-1:0] half_q;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic rise, fall, level, bit_v, lock, capture, timeout, word_done, accept;
  manchester_edge_sync u_sync (
    .clk    (osc),
    .rst    (rst),
    .din_i  (manchester_data),
    .rise_o (rise),
    .fall_o (fall),
    .level_o(level)
  );
  always_comb begin
    bit_v     = (POLARITY != 0) ? level : ~level;
    shift_d   = (LSB_FIRST != 0) ? {bit_v, shift_q[DATA_W-1:1]} : {shift_q[DATA_W-2:0], bit_v};
    lock      = (state_q == IDLE) && rise;
    capture   = (state_q == LOCKED) && (rise || fall) && (cnt_q >= LO) && (cnt_q <= HI);
    timeout   = (state_q == LOCKED) && !capture && (cnt_q == END);
    word_done = capture && (bit_cnt_q == BW'(DATA_W - 1));
    accept    = rx_valid && rx_ready;
    cnt_d     = (state_q == IDLE || capture) ? '0 : (cnt_q == END ? cnt_q : cnt_q + 1'b1);
  end
  always_ff @(posedge osc) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      half_q       <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      balanced_clk <= 1'b0;
      frame_active <= 1'b0;
      bit_err      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_err <= timeout && (bit_cnt_q != '0);
      if (lock) begin
        state_q      <= LOCKED;
        frame_active <= 1'b1;
        bit_cnt_q    <= '0;
        shift_q      <= '0;
      end else if (timeout) begin
        state_q      <= IDLE;
        frame_active <= 1'b0;
        bit_cnt_q    <= '0;
      end else if (capture) begin
        shift_q   <= shift_d;
        bit_cnt_q <= word_done ? '0 : bit_cnt_q + 1'b1;
      end
      // one half-bit high pulse per recovered mid-bit, start bit included
      if (lock || capture) begin
        balanced_clk <= 1'b1;
        half_q       <= HW'(OSR / 2 - 1);
      end else if (half_q != '0) half_q <= half_q - 1'b1;
      else balanced_clk <= 1'b0;
      if (word_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_d;
        rx_valid <= 1'b1;
      end else if (accept) rx_valid <= 1'b0;
      if (accept) overrun <= 1'b0;
      else if (word_done && rx_valid) overrun <= 1'b1;
    end
  end
endmodule
